// File: rtl/mac_seq_pkg.sv
// Shared types and sizing helpers for the MAC sequencer.
package mac_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_RESULT,
        S_FINISH
    } state_t;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ACC_W          = 3 * DATA_WIDTH_DEF;

    function automatic int unsigned acc_width(input int unsigned dw);
        return 3 * dw;
    endfunction

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_seq_cnt.sv
// Modulo-MAX up-counter with synchronous clear and a terminal-count flag.
module mac_seq_cnt
    import mac_seq_pkg::*;
#(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last
);

    assign last = (count == W'(MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequences an external MAC through NUM_ROWS dot products of VEC_LEN operand
// pairs and presents each captured result on a valid/ready port.
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned VEC_LEN    = 8,
    parameter int unsigned NUM_ROWS   = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    output logic                            busy,
    output logic                            done,
    input  logic                            op_valid,
    output logic                            op_ready,
    input  logic [DATA_WIDTH-1:0]           op_a,
    input  logic [DATA_WIDTH-1:0]           op_b,
    output logic                            mac_en,
    output logic                            mac_clr,
    output logic [DATA_WIDTH-1:0]           mac_ain,
    output logic [DATA_WIDTH-1:0]           mac_bin,
    input  logic [3*DATA_WIDTH-1:0]         mac_cout,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [3*DATA_WIDTH-1:0]         res_data,
    output logic [cnt_width(NUM_ROWS)-1:0]  res_row
);

    localparam int unsigned RES_W = acc_width(DATA_WIDTH);
    localparam int unsigned COL_W = cnt_width(VEC_LEN);
    localparam int unsigned ROW_W = cnt_width(NUM_ROWS);

    state_t           state;
    logic             aborting;
    logic             res_valid_q;
    logic             accept;
    logic             start_go;
    logic             col_last;
    logic             row_last;
    logic             row_inc;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic             unused_col;

    assign mac_ain = op_a;
    assign mac_bin = op_b;

    // Abort gates the handshakes combinationally so nothing is consumed or
    // offered in the cancel cycle itself.
    assign accept    = (state == S_ACCUM) && op_valid && !abort;
    assign op_ready  = accept;
    assign mac_en    = accept;
    assign res_valid = res_valid_q && !abort;

    assign start_go = (state == S_IDLE) && start && !abort;
    assign row_inc  = (state == S_RESULT) && res_ready && !row_last && !abort;

    // Column position only matters through its terminal flag.
    assign unused_col = ^col_cnt;

    mac_seq_cnt #(
        .MAX (VEC_LEN),
        .W   (COL_W)
    ) u_col (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == S_CLEAR),
        .inc   (accept),
        .count (col_cnt),
        .last  (col_last)
    );

    mac_seq_cnt #(
        .MAX (NUM_ROWS),
        .W   (ROW_W)
    ) u_row (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_go),
        .inc   (row_inc),
        .count (row_cnt),
        .last  (row_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            aborting    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mac_clr     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data    <= '0;
            res_row     <= '0;
        end else begin
            done    <= 1'b0;
            mac_clr <= 1'b0;
            // Cancel reuses CLEAR for its single clear cycle; the flag sends it home.
            if (abort && state != S_IDLE) begin
                state       <= S_CLEAR;
                aborting    <= 1'b1;
                mac_clr     <= 1'b1;
                res_valid_q <= 1'b0;
                busy        <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_go) begin
                            state   <= S_CLEAR;
                            mac_clr <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        if (aborting) begin
                            state    <= S_IDLE;
                            aborting <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                    S_ACCUM: begin
                        if (accept && col_last) begin
                            state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        res_data    <= RES_W'(mac_cout);
                        res_row     <= row_cnt;
                        res_valid_q <= 1'b1;
                        state       <= S_RESULT;
                    end
                    S_RESULT: begin
                        if (res_ready) begin
                            res_valid_q <= 1'b0;
                            if (row_last) begin
                                state <= S_FINISH;
                                done  <= 1'b1;
                            end else begin
                                state   <= S_CLEAR;
                                mac_clr <= 1'b1;
                            end
                        end
                    end
                    S_FINISH: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with a behavioural MAC in the loop.
module tb_mac_seq_ctrl;

    localparam int DW = 8;
    localparam int VL = 8;
    localparam int NR = 2;
    localparam int AW = 3 * DW;

    typedef struct packed {
        logic [0:0]    row;
        logic [AW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          mac_en;
    logic          mac_clr;
    logic [DW-1:0] mac_ain;
    logic [DW-1:0] mac_bin;
    logic [AW-1:0] mac_cout;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_data;
    logic [0:0]    res_row;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   beat     = 0;
    int   mode     = 0;
    int   stall_left = 0;
    int   t0       = 0;
    bit   toggle_en = 0;
    bit   phase    = 0;
    exp_t exp_q[$];

    mac_seq_ctrl #(
        .DATA_WIDTH (DW),
        .VEC_LEN    (VL),
        .NUM_ROWS   (NR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_ain   (mac_ain),
        .mac_bin   (mac_bin),
        .mac_cout  (mac_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_row   (res_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    // External MAC: shares rst_n, clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mac_cout <= '0;
        else if (mac_clr) mac_cout <= '0;
        else if (mac_en)  mac_cout <= mac_cout + AW'(mac_ain) * AW'(mac_bin);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [2*DW-1:0] operands(input int m, input int b);
        int r;
        int k;
        r = b / VL;
        k = b % VL;
        case (m)
            0:       return {8'd1, 8'd1};
            1:       return {8'(r + 1), 8'(k)};
            default: return {8'hFF, 8'hFF};
        endcase
    endfunction

    // Operand source: the beat index advances only on an accepted pair.
    always begin
        @(negedge clk);
        phase = toggle_en ? ~phase : 1'b1;
        op_valid = phase;
        {op_a, op_b} = operands(mode, beat);
        #1;
        if (op_ready) beat++;
    end

    // Result sink and scoreboard monitor.
    logic          pend = 1'b0;
    logic [AW-1:0] held_data;
    logic [0:0]    held_row;
    exp_t          e;
    always begin
        @(negedge clk);
        if (rst_n && res_valid && stall_left > 0) begin
            res_ready = 1'b0;
            stall_left--;
        end else begin
            res_ready = 1'b1;
        end
        #1;
        if (rst_n && res_valid) begin
            if (pend) begin
                check("res_data_hold", res_data, held_data);
                check("res_row_hold", res_row, held_row);
            end
            if (res_ready) begin
                pend = 1'b0;
                if (exp_q.size() == 0) begin
                    check("res_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_row", res_row, e.row);
                end
            end else begin
                pend      = 1'b1;
                held_data = res_data;
                held_row  = res_row;
            end
        end else begin
            pend = 1'b0;
        end
    end

    // While operands are withheld the MAC must not accumulate.
    always begin
        @(negedge clk);
        #1;
        if (toggle_en && busy && !op_valid) check("no_en_when_idle_op", mac_en, 0);
        if (mac_clr) check("en_clr_exclusive", mac_en, 0);
    end

    task automatic push(input int row, input int data);
        exp_q.push_back('{row: 1'(row), data: AW'(data)});
    endtask

    task automatic start_job(input int m);
        @(negedge clk);
        mode  = m;
        beat  = 0;
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                if (exp_lat > 0) check("done_latency", cyc - t0, exp_lat);
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("idle_after_done", busy, 0);
        end
    endtask

    task automatic wait_beat(input int n);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (beat == n) seen = 1;
        end
        if (!seen) check("beat_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_mac_en"}, mac_en, 0);
        check({tag, "_mac_clr"}, mac_clr, 0);
        check({tag, "_op_ready"}, op_ready, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_res_row"}, res_row, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Unit operands, no stalls; a stray start mid-job must be ignored.
        push(0, 8); push(1, 8);
        start_job(0);
        repeat (4) @(negedge clk);
        check("busy_mid_job", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(23);

        // Row-scaled ramp: row 0 = 1*(0..7) = 28, row 1 = 2*28 = 56.
        push(0, 28); push(1, 56);
        start_job(1);
        wait_done(23);

        // Full-scale operands: 8*255*255 = 520200.
        push(0, 520200); push(1, 520200);
        start_job(2);
        wait_done(23);

        // Alternating operand gaps and a 5-cycle result back-pressure.
        push(0, 28); push(1, 56);
        toggle_en  = 1'b1;
        stall_left = 5;
        start_job(1);
        wait_done(0);
        toggle_en = 1'b0;

        // Abort with three beats of row 1 accepted.
        push(0, 8);
        start_job(0);
        wait_beat(VL + 3);
        d0 = done_cnt;
        abort = 1'b1;
        #2;
        check("abort_op_ready", op_ready, 0);
        check("abort_res_valid", res_valid, 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_clr", mac_clr, 1);
        check("abort_busy", busy, 1);
        check("abort_en", mac_en, 0);
        @(negedge clk);
        #1;
        check("abort_idle_busy", busy, 0);
        check("abort_idle_clr", mac_clr, 0);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, d0);

        push(0, 28); push(1, 56);
        start_job(1);
        wait_done(23);

        // Asynchronous reset during row 1 accumulation.
        push(0, 8);
        start_job(0);
        wait_beat(VL + 2);
        check("pre_reset_res_data", res_data, 8);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        push(0, 8); push(1, 8);
        start_job(0);
        wait_done(23);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer that drives one MAC datapath (multiply-accumulate, 3*DATA_WIDTH accumulator, with En/Clr controls) through a matrix-vector product of NUM_ROWS rows by VEC_LEN columns.
- Consumes operand pairs from an upstream valid/ready stream, one pair per accumulate.
- Issues clear and enable to the MAC, captures each finished dot product, and emits it on a valid/ready result port tagged with its row index.
- Sits between the operand FIFOs/memory loader and the result writer in the minilab top level.

Parameters:
- DATA_WIDTH, 8, operand width; accumulator/result width is 3*DATA_WIDTH.
- VEC_LEN, 8, operand pairs per dot product (>=1).
- NUM_ROWS, 8, dot products per job (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job start; honoured only in IDLE.
- abort  in  1  synchronous job cancel.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  operand pair accepted this cycle.
- op_a  in  DATA_WIDTH  operand A.
- op_b  in  DATA_WIDTH  operand B.
- mac_en  out  1  MAC accumulate enable.
- mac_clr  out  1  MAC accumulator clear.
- mac_ain  out  DATA_WIDTH  equals op_a (combinational pass-through).
- mac_bin  out  DATA_WIDTH  equals op_b (combinational pass-through).
- mac_cout  in  3*DATA_WIDTH  MAC accumulator value.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  3*DATA_WIDTH  captured dot product.
- res_row  out  clog2(NUM_ROWS) (minimum 1)  row index of res_data.

Behaviour:
- Reset:
  - State IDLE; col/row counters 0; res_data 0.
  - res_row 0; busy/done/res_valid/mac_en/mac_clr/op_ready all 0.
- States: IDLE, CLEAR, ACCUM, DRAIN, RESULT, FINISH.
- IDLE: start=1 -> CLEAR, row<=0.
- CLEAR: mac_clr=1 for exactly one cycle, col<=0 -> ACCUM.
- ACCUM:
  - op_ready = mac_en = op_valid (combinational). A beat is accepted when op_valid=1.
  - op_valid=0 stalls with no accumulate and no counter change.
  - On each accepted beat col++. The beat with col==VEC_LEN-1 -> DRAIN.
- DRAIN: one cycle, no enable. The MAC register has now absorbed the last product. res_data<=mac_cout, res_row<=row -> RESULT.
- RESULT:
  - res_valid=1; res_data and res_row are held stable until res_ready=1.
  - On handshake: if row==NUM_ROWS-1 -> FINISH, else row++ -> CLEAR.
- FINISH: done=1 for one cycle -> IDLE.
- Per-row latency with no stalls: 1 (CLEAR) + VEC_LEN (ACCUM) + 1 (DRAIN) + 1 (RESULT) = VEC_LEN+3 cycles.
- Full job with no stalls: NUM_ROWS*(VEC_LEN+3)+1 cycles from start to done.
- Width: no truncation. The 3*DATA_WIDTH result is the raw MAC value; overflow wraps inside the MAC and is not flagged.
- start while busy: ignored, with no effect on counters.
- abort in any non-IDLE state:
  - Next state CLEAR-then-IDLE: one cycle of mac_clr=1, then IDLE.
  - No done pulse. res_valid drops immediately. Operand beats are not accepted in the abort cycle (op_ready=0).
- abort and start in the same IDLE cycle: abort wins and the state stays IDLE.
- res_ready ignored outside RESULT.
- Asynchronous reset mid-job returns to IDLE with the reset values above. The MAC shares rst_n, so its accumulator is also cleared.
- mac_en and mac_clr are never asserted in the same cycle.

Decomposition:
- Package mac_seq_pkg: state enum type, localparam ACC_W = 3*DATA_WIDTH helper, and counter width function (clog2 with a minimum of 1).
- One sub-module is natural: mac_seq_cnt, a generic up-counter with clear, inc and terminal-count flag. It is instantiated twice, for col and row.
- The MAC itself is instantiated outside, in the top level.

Test Plan:
- VEC_LEN=8, NUM_ROWS=2, all operands 1, res_ready tied 1, op_valid tied 1 -> results 8 (row 0) and 8 (row 1); done pulse exactly 23 cycles after start.
- Row r operands a=r+1, b=k for k=0..7 -> row 0 = 28, row 1 = 56; res_row matches.
- All operands 255, VEC_LEN=8 -> 520200 (0x07F008) with no truncation.
- op_valid toggled 1/0 each cycle and res_ready held 0 for 5 cycles -> results unchanged from the no-stall case; res_data stable while res_valid=1; no accumulate while op_valid=0.
- abort at col=3 of row 1 -> one mac_clr cycle, then IDLE, busy=0, no done. A following start computes row 0 correctly from zero.
- rst_n asserted mid-ACCUM and start pulsed while busy -> all outputs return to reset values asynchronously; start while busy causes no restart.
